sync_posedge_filter: RTL and testbench



---
 rtl/sync_posedge_filter_if.sv | 14 +
 rtl/sync_posedge_filter.sv | 100 ++++++++++
 tb/tb_sync_posedge_filter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_posedge_filter_if.sv
// Signal bundle between the asynchronous delay generator side and the
// clocked edge filter: raw level in, filtered level and edge events out.
interface sync_posedge_filter_if #(
  parameter int CW = 8
) ();
  logic          x;
  logic          z;
  logic          rise;
  logic          glitch;
  logic [CW-1:0] count;

  modport master (output x, input z, rise, glitch, count);
  modport slave  (input x, output z, rise, glitch, count);
endinterface

// File: rtl/sync_posedge_filter.sv
// Synchronizes an asynchronous level and re-qualifies each rising edge:
// z rises after N consecutive high samples, falls after synchronizer latency.
module sync_posedge_filter #(
  parameter int N  = 5,
  parameter int CW = 8
) (
  input  logic                  clock,
  input  logic                  reset_,
  sync_posedge_filter_if.slave  bus
);

  localparam int CNT_W = $clog2(N);

  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  if (N < 2) begin : g_bad_n
    $error("sync_posedge_filter: N must be >= 2");
  end

  logic             s1_q, xs_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             rise_q, rise_d;
  logic             glitch_q, glitch_d;
  logic [CW-1:0]    count_q, count_d;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    glitch_d = 1'b0;
    count_d  = count_q;
    case (state_q)
      ST_LOW: begin
        if (xs_q) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!xs_q) begin
          state_d  = ST_LOW;
          glitch_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_HIGH;
          rise_d  = 1'b1;
          count_d = count_q + 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (!xs_q) state_d = ST_LOW;
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
    // z is registered from the next state so it is a clean flop output.
    z_d = (state_d == ST_HIGH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what makes s1 -> xs a two-stage chain.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      s1_q     <= 1'b0;
      xs_q     <= 1'b0;
      state_q  <= ST_LOW;
      cnt_q    <= '0;
      z_q      <= 1'b0;
      rise_q   <= 1'b0;
      glitch_q <= 1'b0;
      count_q  <= '0;
    end else begin
      s1_q     <= bus.x;
      xs_q     <= s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      rise_q   <= rise_d;
      glitch_q <= glitch_d;
      count_q  <= count_d;
    end
  end

  assign bus.z      = z_q;
  assign bus.rise   = rise_q;
  assign bus.glitch = glitch_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_sync_posedge_filter.sv
// Directed bench: dut_a (N=5, CW=8) covers rise/fall/glitch/reset cases,
// dut_b (N=2, CW=4) covers counter wrap-around.
module tb_sync_posedge_filter;

  logic clock;
  logic reset_;

  sync_posedge_filter_if #(.CW(8)) bus_a ();
  sync_posedge_filter_if #(.CW(4)) bus_b ();

  sync_posedge_filter #(.N(5), .CW(8)) dut_a (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus_a)
  );

  sync_posedge_filter #(.N(2), .CW(4)) dut_b (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge, then settle at the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_  = 1'b0;
    bus_a.x = 1'b1;
    bus_b.x = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== 11'd0) begin
        n_mis++;
        $display("FAIL reset_a k=%0d: got z=%b rise=%b glitch=%b count=%0d, want all 0",
                 k, bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count);
      end
      n_cmp++;
      if ({bus_b.z, bus_b.rise, bus_b.glitch, bus_b.count} !== 7'd0) begin
        n_mis++;
        $display("FAIL reset_b k=%0d: got z=%b rise=%b glitch=%b count=%0d, want all 0",
                 k, bus_b.z, bus_b.rise, bus_b.glitch, bus_b.count);
      end
    end
    bus_a.x = 1'b0;
    bus_b.x = 1'b0;
    tick();
    reset_ = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    n_cmp++;
    if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== 11'd0) begin
      n_mis++;
      $display("FAIL reset_release: got z=%b rise=%b glitch=%b count=%0d, want all 0",
               bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count);
    end
  endtask

  // x held high from e0: z/rise/count change after e6, rise clears after e7.
  task automatic test_accept();
    logic       ez, er;
    logic [7:0] ec;
    bus_a.x = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      ez = (k >= 6);
      er = (k == 6);
      ec = (k >= 6) ? 8'd1 : 8'd0;
      n_cmp++;
      if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== {ez, er, 1'b0, ec}) begin
        n_mis++;
        $display("FAIL accept e%0d: got z=%b rise=%b glitch=%b count=%0d, want z=%b rise=%b glitch=0 count=%0d",
                 k, bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count, ez, er, ec);
      end
    end
  endtask

  // x low captured at f0: z drops after f2, no event pulses.
  task automatic test_fall();
    logic ez;
    bus_a.x = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      ez = (k < 2);
      n_cmp++;
      if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== {ez, 1'b0, 1'b0, 8'd1}) begin
        n_mis++;
        $display("FAIL fall f%0d: got z=%b rise=%b glitch=%b count=%0d, want z=%b rise=0 glitch=0 count=1",
                 k, bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count, ez);
      end
    end
  endtask

  // x high for edges e0..e2 only: WAIT sees xs=0 at e5 -> glitch after e5 only.
  task automatic test_glitch();
    logic eg;
    bus_a.x = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 2) bus_a.x = 1'b0;
      eg = (k == 5);
      n_cmp++;
      if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== {1'b0, 1'b0, eg, 8'd1}) begin
        n_mis++;
        $display("FAIL glitch e%0d: got z=%b rise=%b glitch=%b count=%0d, want z=0 rise=0 glitch=%b count=1",
                 k, bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count, eg);
      end
    end
  endtask

  // From HIGH, one low sample drops z after f2, then a fresh rise after f7.
  task automatic test_single_low();
    logic       ez, er;
    logic [7:0] ec;
    bus_a.x = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    n_cmp++;
    if ({bus_a.z, bus_a.count} !== {1'b1, 8'd2}) begin
      n_mis++;
      $display("FAIL single_low_pre: got z=%b count=%0d, want z=1 count=2", bus_a.z, bus_a.count);
    end
    bus_a.x = 1'b0;
    tick();
    bus_a.x = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ez = (k < 2) || (k >= 7);
      er = (k == 7);
      ec = (k >= 7) ? 8'd3 : 8'd2;
      n_cmp++;
      if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== {ez, er, 1'b0, ec}) begin
        n_mis++;
        $display("FAIL single_low f%0d: got z=%b rise=%b glitch=%b count=%0d, want z=%b rise=%b glitch=0 count=%0d",
                 k, bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count, ez, er, ec);
      end
    end
    bus_a.x = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  // N=2: rise after e3 of each high burst; 16 rises wrap the 4-bit count to 0.
  task automatic test_wrap();
    logic [3:0] ec;
    logic       er;
    ec = 4'd0;
    for (int i = 0; i < 16; i++) begin
      bus_b.x = 1'b1;
      for (int k = 0; k <= 4; k++) begin
        tick();
        er = (k == 3);
        if (k == 3) ec = ec + 4'd1;
        n_cmp++;
        if ({bus_b.rise, bus_b.glitch, bus_b.count} !== {er, 1'b0, ec}) begin
          n_mis++;
          $display("FAIL wrap i=%0d e%0d: got rise=%b glitch=%b count=%0d, want rise=%b glitch=0 count=%0d",
                   i, k, bus_b.rise, bus_b.glitch, bus_b.count, er, ec);
        end
      end
      bus_b.x = 1'b0;
      for (int k = 0; k < 4; k++) tick();
    end
    n_cmp++;
    if ({bus_b.z, bus_b.count} !== {1'b0, 4'd0}) begin
      n_mis++;
      $display("FAIL wrap_final: got z=%b count=%0d, want z=0 count=0", bus_b.z, bus_b.count);
    end
  endtask

  // Reset after e4 (cnt=3) aborts WAIT silently; with x held high the
  // 7th edge after release gives the rise.
  task automatic test_reset_mid_wait();
    logic       ez, er;
    logic [7:0] ec;
    bus_a.x = 1'b1;
    for (int k = 0; k <= 4; k++) tick();
    reset_ = 1'b0;
    #1;
    n_cmp++;
    if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== 11'd0) begin
      n_mis++;
      $display("FAIL mid_wait_reset: got z=%b rise=%b glitch=%b count=%0d, want all 0",
               bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count);
    end
    tick();
    reset_ = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ez = (k >= 7);
      er = (k == 7);
      ec = (k >= 7) ? 8'd1 : 8'd0;
      n_cmp++;
      if ({bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count} !== {ez, er, 1'b0, ec}) begin
        n_mis++;
        $display("FAIL mid_wait_release edge%0d: got z=%b rise=%b glitch=%b count=%0d, want z=%b rise=%b glitch=0 count=%0d",
                 k, bus_a.z, bus_a.rise, bus_a.glitch, bus_a.count, ez, er, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accept();
    test_fall();
    test_glitch();
    test_single_low();
    test_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
